time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/clock24_pkg.sv | 34 +++
 rtl/debounce.sv | 56 +++++
 rtl/time_set_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/clock24_pkg.sv
// Shared definitions for the clock24 time-setting controller:
// FSM state encoding, button-owner codes and default timing constants.
package clock24_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIRST    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    // Which button currently owns the controller
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_H    = 2'd1,
        OWN_M    = 2'd2,
        OWN_C    = 2'd3
    } owner_t;

    // Default timing, all in 1 ms tick units
    localparam int DEB_MS_DEF     = 20;
    localparam int RPT_DLY_MS_DEF = 500;
    localparam int RPT_MS_DEF     = 100;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int timer_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce.sv
// One button input: 2-flop synchronizer followed by a tick-based
// debouncer. The output level only follows the synchronized input after
// DEB_MS consecutive ms samples at the new level.
module debounce
    import clock24_pkg::*;
#(
    parameter int DEB_MS = DEB_MS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce1,
    input  logic btn,
    output logic level
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_MS - 1);

    logic       sync1_reg;
    logic       sync2_reg;
    logic [7:0] cnt_reg;
    logic       level_reg;

    // Bring the raw asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive ms samples that disagree with the current level;
    // any agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (ce1) begin
            if (sync2_reg != level_reg) begin
                if (cnt_reg == DEB_LAST) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller for counter24: debounces the hour, minute and
// clear buttons and turns presses into single or auto-repeating one-cycle
// set/clear pulses. One button owns the controller until all are released.
module time_set_ctrl
    import clock24_pkg::*;
#(
    parameter int DEB_MS     = DEB_MS_DEF,
    parameter int RPT_DLY_MS = RPT_DLY_MS_DEF,
    parameter int RPT_MS     = RPT_MS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce1,
    input  logic btnh,
    input  logic btnm,
    input  logic btnc,
    output logic seth,
    output logic setm,
    output logic sclr,
    output logic active
);

    localparam int TW = timer_width(RPT_DLY_MS);
    localparam logic [TW-1:0] DLY_LAST  = TW'(RPT_DLY_MS);
    localparam logic [TW-1:0] RPT_LAST  = TW'(RPT_MS);
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    // Bit 0 = hour, bit 1 = minute, bit 2 = clear
    logic [2:0] btn_raw;
    logic [2:0] deb;

    assign btn_raw = {btnc, btnm, btnh};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            debounce #(
                .DEB_MS (DEB_MS)
            ) u_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .ce1   (ce1),
                .btn   (btn_raw[gi]),
                .level (deb[gi])
            );
        end
    endgenerate

    state_t        state_reg;
    owner_t        owner_reg;
    logic [TW-1:0] timer_reg;
    logic          seth_reg;
    logic          setm_reg;
    logic          sclr_reg;
    logic          active_reg;

    logic          owner_level;
    logic [TW-1:0] timer_inc;

    // Debounced level of whichever button owns the controller
    always_comb begin
        owner_level = 1'b0;
        case (owner_reg)
            OWN_H:   owner_level = deb[0];
            OWN_M:   owner_level = deb[1];
            OWN_C:   owner_level = deb[2];
            default: owner_level = 1'b0;
        endcase
    end

    // Saturating increment so a stalled timer can never wrap to zero
    assign timer_inc = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + TIMER_ONE;

    // Controller FSM with tick timer and registered pulse/active outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= OWN_NONE;
            timer_reg  <= '0;
            seth_reg   <= 1'b0;
            setm_reg   <= 1'b0;
            sclr_reg   <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            seth_reg <= 1'b0;
            setm_reg <= 1'b0;
            sclr_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|deb) begin
                        // Clear beats hour beats minute
                        if (deb[2]) begin
                            owner_reg <= OWN_C;
                        end else if (deb[0]) begin
                            owner_reg <= OWN_H;
                        end else begin
                            owner_reg <= OWN_M;
                        end
                        state_reg  <= ST_FIRST;
                        active_reg <= 1'b1;
                    end
                end
                ST_FIRST: begin
                    seth_reg  <= (owner_reg == OWN_H);
                    setm_reg  <= (owner_reg == OWN_M);
                    sclr_reg  <= (owner_reg == OWN_C);
                    timer_reg <= '0;
                    // Clear never repeats
                    state_reg <= (owner_reg == OWN_C) ? ST_WAIT_REL : ST_HOLD;
                end
                ST_HOLD: begin
                    if (!owner_level) begin
                        state_reg <= ST_WAIT_REL;
                    end else if (ce1) begin
                        if (timer_inc >= DLY_LAST) begin
                            seth_reg  <= (owner_reg == OWN_H);
                            setm_reg  <= (owner_reg == OWN_M);
                            timer_reg <= '0;
                            state_reg <= ST_REPEAT;
                        end else begin
                            timer_reg <= timer_inc;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!owner_level) begin
                        state_reg <= ST_WAIT_REL;
                    end else if (ce1) begin
                        if (timer_inc >= RPT_LAST) begin
                            seth_reg  <= (owner_reg == OWN_H);
                            setm_reg  <= (owner_reg == OWN_M);
                            timer_reg <= '0;
                        end else begin
                            timer_reg <= timer_inc;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    // Other buttons pressed meanwhile must also be let go
                    if (deb == 3'b000) begin
                        state_reg  <= ST_IDLE;
                        owner_reg  <= OWN_NONE;
                        active_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    owner_reg  <= OWN_NONE;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign seth   = seth_reg;
    assign setm   = setm_reg;
    assign sclr   = sclr_reg;
    assign active = active_reg;

endmodule
